write_ptr_full: RTL and testbench
=================================

// Module: write_ptr_full
// PURPOSE
//  Write-domain pointer and full-flag logic of the asynchronous FIFO.
//  Counterpart of the read-side pointer/empty block.
//  - Advances the binary and Gray write pointers on accepted writes.
//  - Compares the next Gray write pointer against the read Gray pointer
//    synchronised into wr_clk, and raises full.
//  - Also provides a sticky overflow flag and, optionally, fill level and
//    almost-full outputs.
// PARAMETERS
//  NUM_BITS   4  pointer width incl. wrap bit; FIFO depth = 2**(NUM_BITS-1); legal range >=3
//  AF_THRESH  6  almost_full asserts when level >= AF_THRESH (WR_FILL_LEVEL_EN only); legal range 1..DEPTH
// PORTS
//  wr_clk           in   1         write clock
//  wr_rst           in   1         async reset, active-low
//  wr_en            in   1         write request
//  ovf_clr          in   1         synchronous clear of overflow
//  rd_ptr_gray_sync in   NUM_BITS  read Gray pointer, already 2-FF synced to wr_clk
//  wr_ptr_bin       out  NUM_BITS  binary write pointer; [NUM_BITS-2:0] is the RAM write address
//  wr_ptr_gray      out  NUM_BITS  Gray write pointer, to read-domain synchroniser
//  full             out  1         FIFO full
//  overflow         out  1         sticky: a write was attempted while full
//  wr_level         out  NUM_BITS  entries held, 0..DEPTH (WR_FILL_LEVEL_EN only)
//  almost_full      out  1         level >= AF_THRESH (WR_FILL_LEVEL_EN only)
// BEHAVIOUR
//  Reset (wr_rst=0, async):
//  - wr_ptr_bin, wr_ptr_gray, full, overflow, wr_level and almost_full all go to 0.
//  Accepted write:
//  - wr_inc = wr_en & ~full.
//  - bin_nxt = wr_ptr_bin + wr_inc, mod 2**NUM_BITS; wraps to 0 with no special case.
//  - gray_nxt = bin_nxt ^ (bin_nxt >> 1).
//  - Both pointers register their _nxt values every wr_clk edge.
//  - The caller's RAM write uses the pre-increment wr_ptr_bin in the same cycle.
//  Full flag:
//  - full <= (gray_nxt == {~rd_ptr_gray_sync[N-1:N-2], rd_ptr_gray_sync[N-3:0]}), registered.
//  - full asserts in the cycle after the write that fills the last entry.
//    wr_en is ignored while full: pointers hold and no RAM write occurs.
//  - full deasserts one wr_clk after rd_ptr_gray_sync changes.
//    Read-side frees are therefore seen late (2 sync + 1 reg); this is conservative and safe.
//  Overflow:
//  - Set when wr_en & full.
//  - Cleared when ovf_clr=1 and no overflow-setting event occurs that cycle; set wins on a tie.
//  Simultaneous write and read-pointer change:
//  - Both are absorbed in the same compare; full reflects the net state.
//  Reset mid-operation:
//  - All outputs clear immediately, with no glitch-free requirement on the RAM side.
//  - Reset of both domains is the system's responsibility.
// CONFIGURATION
//  `WR_FILL_LEVEL_EN defined:
//  - rd_bin_sync = Gray-to-binary of rd_ptr_gray_sync (XOR prefix from the MSB).
//  - wr_level <= bin_nxt - rd_bin_sync, mod 2**NUM_BITS; registered, aligned with full.
//  - almost_full <= (level_nxt >= AF_THRESH), registered.
//  - full=1 implies wr_level == DEPTH.
//  `WR_FILL_LEVEL_EN undefined:
//  - The wr_level and almost_full ports, the converter and the subtractor are absent.
//  - All other behaviour is identical.
// TESTING (NUM_BITS=4, DEPTH=8, AF_THRESH=6, WR_FILL_LEVEL_EN defined)
//  1 Reset: wr_rst=0 mid-clock -> all outputs 0 asynchronously; hold 0 after release with wr_en=0.
//  2 Fill: rd_sync=0, 8 consecutive wr_en=1 -> wr_ptr_bin steps 0..8; full=1 the cycle after the 8th write;
//    wr_ptr_gray=4'b1100; wr_level=8; almost_full rises after the 6th write.
//  3 Overflow: while full, wr_en=1 for 3 cycles -> pointers hold at 8, overflow=1;
//    ovf_clr=1 with wr_en=0 -> overflow=0 next cycle; ovf_clr=1 with wr_en=1 -> overflow stays 1.
//  4 Drain/resume: from full, rd_sync=Gray(3)=4'b0010 -> full=0 and wr_level=5 next cycle;
//    3 writes -> full again with wr_ptr_bin=11.
//  5 Wrap: stream writes and track reads until wr_ptr_bin passes 15 -> 0.
//    Gray must change 1 bit per step, no false full at wrap, and level must be consistent throughout.
//  6 Simultaneous: at level 7, wr_en=1 in the same cycle rd_sync advances by 1 -> level stays 7, full=0.

Source files
------------

// File: rtl/write_ptr_full.sv
// write_ptr_full: async-FIFO write pointer, full and sticky overflow; fill level and
// almost_full exist only when WR_FILL_LEVEL_EN is defined.
module write_ptr_full #(
   parameter int NUM_BITS  = 4,
   parameter int AF_THRESH = 6
) (
   input  logic                wr_clk,
   input  logic                wr_rst,
   input  logic                wr_en,
   input  logic                ovf_clr,
   input  logic [NUM_BITS-1:0] rd_ptr_gray_sync,
   output logic [NUM_BITS-1:0] wr_ptr_bin,
   output logic [NUM_BITS-1:0] wr_ptr_gray,
   output logic                full,
   output logic                overflow
`ifdef WR_FILL_LEVEL_EN
   ,
   output logic [NUM_BITS-1:0] wr_level,
   output logic                almost_full
`endif
);
   if (NUM_BITS < 3 || AF_THRESH < 1 || AF_THRESH > 2**(NUM_BITS-1)) begin : g_bad_param
      $error("write_ptr_full: illegal NUM_BITS/AF_THRESH");
   end
   logic                wr_inc;
   logic [NUM_BITS-1:0] bin_nxt, gray_nxt, rd_full_cmp;
   logic                full_nxt, ovf_nxt;
   always_comb begin
      wr_inc      = wr_en & ~full;
      bin_nxt     = wr_ptr_bin + {{(NUM_BITS-1){1'b0}}, wr_inc};
      gray_nxt    = bin_nxt ^ (bin_nxt >> 1);
      rd_full_cmp = {~rd_ptr_gray_sync[NUM_BITS-1:NUM_BITS-2], rd_ptr_gray_sync[NUM_BITS-3:0]};
      full_nxt    = gray_nxt == rd_full_cmp;
      ovf_nxt     = (wr_en & full) | (overflow & ~ovf_clr);
   end
   always_ff @(posedge wr_clk or negedge wr_rst)
      if (!wr_rst) begin
         wr_ptr_bin  <= '0;
         wr_ptr_gray <= '0;
         full        <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         wr_ptr_bin  <= bin_nxt;
         wr_ptr_gray <= gray_nxt;
         full        <= full_nxt;
         overflow    <= ovf_nxt;
      end
`ifdef WR_FILL_LEVEL_EN
   logic [NUM_BITS-1:0] rd_bin_sync, level_nxt;
   // each binary bit is the XOR of all Gray bits at and above it
   always_comb begin
      for (int i = 0; i < NUM_BITS; i++) rd_bin_sync[i] = ^(rd_ptr_gray_sync >> i);
      level_nxt = bin_nxt - rd_bin_sync;
   end
   always_ff @(posedge wr_clk or negedge wr_rst)
      if (!wr_rst) begin
         wr_level    <= '0;
         almost_full <= 1'b0;
      end else begin
         wr_level    <= level_nxt;
         almost_full <= level_nxt >= NUM_BITS'(AF_THRESH);
      end
`endif
endmodule

// File: tb/tb_write_ptr_full.sv
// tb_write_ptr_full: random and directed stimulus against an occupancy-count model of
// the write side; level outputs are checked only when WR_FILL_LEVEL_EN is defined.
module tb_write_ptr_full;
   logic       wr_clk = 1'b0;
   logic       wr_rst = 1'b1;
   logic       wr_en = 1'b0;
   logic       ovf_clr = 1'b0;
   logic [3:0] rd_ptr_gray_sync;
   logic [3:0] wr_ptr_bin, wr_ptr_gray;
   logic       full, overflow;
`ifdef WR_FILL_LEVEL_EN
   logic [3:0] wr_level;
   logic       almost_full;
`endif
   int n_chk = 0, n_fail = 0, wraps = 0;
   int rd_cnt = 0;
   bit go = 1'b0;
   int m_wr = 0, m_level = 0;
   bit m_full = 1'b0, m_ovf = 1'b0, m_af = 1'b0;
   logic [3:0] prev_g = '0, prev_b = '0;

   always #5 wr_clk = ~wr_clk;

   function automatic logic [3:0] gray(input int v);
      logic [3:0] b;
      b = 4'(v & 15);
      return b ^ (b >> 1);
   endfunction

   assign rd_ptr_gray_sync = gray(rd_cnt);

   write_ptr_full #(.NUM_BITS(4), .AF_THRESH(6)) dut (
      .wr_clk(wr_clk), .wr_rst(wr_rst), .wr_en(wr_en), .ovf_clr(ovf_clr),
      .rd_ptr_gray_sync(rd_ptr_gray_sync), .wr_ptr_bin(wr_ptr_bin), .wr_ptr_gray(wr_ptr_gray),
      .full(full), .overflow(overflow)
`ifdef WR_FILL_LEVEL_EN
      , .wr_level(wr_level), .almost_full(almost_full)
`endif
   );

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // occupancy model: accepted writes minus reads seen, full at exactly DEPTH entries
   always @(posedge wr_clk or negedge wr_rst)
      if (!wr_rst) begin
         m_wr <= 0; m_level <= 0; m_full <= 1'b0; m_ovf <= 1'b0; m_af <= 1'b0;
      end else begin
         int nw, lvl;
         nw = m_wr + ((wr_en && !m_full) ? 1 : 0);
         lvl = (nw - rd_cnt) & 15;
         m_wr <= nw;
         m_level <= lvl;
         m_full <= lvl == 8;
         m_af <= lvl >= 6;
         m_ovf <= (wr_en && m_full) || (m_ovf && !ovf_clr);
      end

   always @(negedge wr_clk) if (go) begin
      chk("wr_ptr_bin", int'(wr_ptr_bin), m_wr & 15);
      chk("wr_ptr_gray", int'(wr_ptr_gray), int'(gray(m_wr)));
      chk("full", int'(full), int'(m_full));
      chk("overflow", int'(overflow), int'(m_ovf));
`ifdef WR_FILL_LEVEL_EN
      chk("wr_level", int'(wr_level), m_level);
      chk("almost_full", int'(almost_full), int'(m_af));
      if (full) chk("level_at_full", int'(wr_level), 8);
`endif
      if (wr_rst) begin
         chk("gray_one_bit_step", ($countones(prev_g ^ wr_ptr_gray) <= 1) ? 1 : 0, 1);
         if (prev_b == 4'd15 && wr_ptr_bin == 4'd0) wraps++;
      end
      prev_g = wr_rst ? wr_ptr_gray : 4'd0;
      prev_b = wr_rst ? wr_ptr_bin : 4'd0;
   end

   task automatic cyc(input logic we, input logic oc);
      wr_en = we;
      ovf_clr = oc;
      @(negedge wr_clk);
      #1;
   endtask

   initial begin
      #1 wr_rst = 1'b0;
      go = 1'b1;
      repeat (2) @(negedge wr_clk);
      #1 wr_rst = 1'b1;
      repeat (2) cyc(0, 0);
      chk("idle_bin", int'(wr_ptr_bin), 0);
      chk("idle_full", int'(full), 0);
      repeat (3) cyc(1, 0);
      chk("pre_rst_bin", int'(wr_ptr_bin), 3);
      // reset mid-clock: outputs drop without waiting for an edge
      @(posedge wr_clk);
      #2 wr_rst = 1'b0;
      #1;
      chk("async_rst_bin", int'(wr_ptr_bin), 0);
      chk("async_rst_gray", int'(wr_ptr_gray), 0);
      chk("async_rst_full", int'(full), 0);
      chk("async_rst_ovf", int'(overflow), 0);
      @(negedge wr_clk);
      #1 wr_rst = 1'b1;
      wr_en = 1'b0;
      repeat (2) cyc(0, 0);
      chk("post_rst_bin", int'(wr_ptr_bin), 0);
      // fill
      for (int i = 1; i <= 8; i++) begin
         cyc(1, 0);
         chk("fill_bin", int'(wr_ptr_bin), i);
         chk("fill_full", int'(full), (i == 8) ? 1 : 0);
`ifdef WR_FILL_LEVEL_EN
         chk("fill_af", int'(almost_full), (i >= 6) ? 1 : 0);
`endif
      end
      chk("fill_gray", int'(wr_ptr_gray), 4'b1100);
`ifdef WR_FILL_LEVEL_EN
      chk("fill_level", int'(wr_level), 8);
`endif
      // overflow
      repeat (3) cyc(1, 0);
      chk("ovf_bin_hold", int'(wr_ptr_bin), 8);
      chk("ovf_set", int'(overflow), 1);
      cyc(0, 1);
      chk("ovf_clr", int'(overflow), 0);
      cyc(1, 0);
      chk("ovf_reset", int'(overflow), 1);
      cyc(1, 1);
      chk("ovf_set_wins", int'(overflow), 1);
      cyc(0, 0);
      // drain and resume
      rd_cnt = 3;
      cyc(0, 0);
      chk("drain_full", int'(full), 0);
`ifdef WR_FILL_LEVEL_EN
      chk("drain_level", int'(wr_level), 5);
`endif
      repeat (3) cyc(1, 0);
      chk("resume_bin", int'(wr_ptr_bin), 11);
      chk("resume_full", int'(full), 1);
      // simultaneous write and read advance at level 7
      rd_cnt = 4;
      cyc(0, 0);
      rd_cnt = 5;
      cyc(1, 0);
      chk("simul_bin", int'(wr_ptr_bin), 12);
      chk("simul_full", int'(full), 0);
`ifdef WR_FILL_LEVEL_EN
      chk("simul_level", int'(wr_level), 7);
`endif
      // random streaming through several wraps
      for (int i = 0; i < 600; i++) begin
         if (rd_cnt < m_wr && $urandom_range(99) < 45) rd_cnt = rd_cnt + 1;
         cyc(($urandom_range(99) < 65) ? 1'b1 : 1'b0, ($urandom_range(99) < 10) ? 1'b1 : 1'b0);
      end
      chk("wrap_seen", (wraps > 0) ? 1 : 0, 1);
      wr_en = 1'b0;
      ovf_clr = 1'b0;
      @(posedge wr_clk);
      #3 wr_rst = 1'b0;
      #1;
      chk("end_rst_bin", int'(wr_ptr_bin), 0);
      chk("end_rst_ovf", int'(overflow), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
